cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares a small number of common-data-bus broadcast ports among the reservation-station execution outputs (4 ALU stations + branch station) with rotating priority. Each requester presents {tag, data} under a valid/ready handshake. Winners are registered and broadcast on the bus ports one cycle later, where they feed the ROB valid bits, waiting reservation stations and regfile commit. Sits between the reservation stations/ALUs and the cdb block; replaces direct per-tag CDB writes when more requesters than ports complete in one cycle.

Parameters:
NUM_REQ, 5, number of requesters; index NUM_REQ-1 is the branch station
NUM_PORTS, 2, number of broadcast ports per cycle (1..NUM_REQ)
TAG_W, 3, ROB tag width (8-entry ROB)
DATA_W, 32, result data width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  branch-mispredict flush; kills pending and registered broadcasts
req_valid  input  NUM_REQ  requester i has a result
req_tag  input  NUM_REQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
req_data  input  NUM_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  grant; transfer occurs when req_valid[i] & req_ready[i]
bus_valid  output  NUM_PORTS  port k carries a broadcast this cycle
bus_tag  output  NUM_PORTS*TAG_W  broadcast ROB tag per port
bus_data  output  NUM_PORTS*DATA_W  broadcast data per port
rr_ptr_o  output  clog2(NUM_REQ)  current highest-priority requester index (debug)

Behaviour:
- Reset, synchronous on rst high: bus_valid=0, bus_tag=0, bus_data=0, rr_ptr=0. req_ready is combinational and is 0 while rst is high.
- Handshake: a requester holds valid, tag and data stable until it sees ready. req_valid must not depend on req_ready. req_ready[i]=0 whenever req_valid[i]=0.
- Grant, combinational: scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first NUM_PORTS with valid=1 get ready=1. The j-th winner in scan order maps to port j.
- Latency: a grant in cycle t produces bus_valid[j], bus_tag and bus_data in cycle t+1. Output registers are loaded every cycle. Ports with no winner get valid=0 and hold tag/data at 0.
- Pointer update: if there is at least one grant, rr_ptr <= (index of last winner + 1) mod NUM_REQ. With no grant, rr_ptr holds.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_PORTS) cycles. Defaults: at most 3 cycles.
- Fewer valid requesters than ports: all valid requesters are granted the same cycle, and the upper ports stay idle.
- Wrap-around: with rr_ptr=4 and valid={0,1,0,0,1} (index 4 first), grant order is 4 then 1. Port0 gets requester 4, port1 gets requester 1, next rr_ptr=2.
- Flush, same cycle: req_ready forced to 0. bus_valid <= 0 next cycle. rr_ptr <= 0.
- Simultaneous flush+rst: reset wins; the result is identical.
- Flush does not retract a broadcast already visible this cycle. The ROB ignores tags past br_flush_ptr.
- Duplicate tags across requesters are illegal upstream. Behaviour with duplicates is undefined and needs no check.

Optional Feature:
Macro CDB_ARB_BR_PRIORITY_EN.
- Defined: requester NUM_REQ-1 (branch) has fixed top priority. When valid, it always takes port 0 and the remaining ports follow round-robin over the other requesters. rr_ptr never points at NUM_REQ-1 and updates using ALU winners only.
- Undefined: the branch station is a normal round-robin member.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 → req_ready=0, bus_valid=00, rr_ptr_o=0. First post-reset cycle grants req 0,1; next cycle bus_tag={1,0} for tags 0 and 1.
- Single requester: req_valid=00100, tag=5, data=0xDEADBEEF → req_ready=00100; next cycle bus_valid=01, bus_tag[0]=5, bus_data[0]=0xDEADBEEF; rr_ptr=3.
- Saturation: all 5 valid with unique tags, each dropping valid after grant → grant order {0,1},{2,3},{4}. Every tag appears exactly once on the bus over 3 cycles; rr_ptr sequence 0→2→4→0.
- Wrap: force rr_ptr=4 (prior grant pattern), valid=10010 (bits 4 and 1) → port0=req4, port1=req1, rr_ptr=2.
- Flush: cycle t grants req 0,1; flush=1 at t+1 with req 2,3 valid → t+1 bus shows req 0,1 and req_ready=0. At t+2 bus_valid=00 and rr_ptr=0.
- CDB_ARB_BR_PRIORITY_EN: rr_ptr=1, all valid → port0=req4, port1=req1, rr_ptr=2. Without the macro → port0=req1, port1=req2.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares NUM_PORTS common-data-bus broadcast ports among NUM_REQ execution
//   result requesters (ALU stations plus the branch station at index
//   NUM_REQ-1). The arbiter grants requesters in rotating priority order.
//   Winners are registered and broadcast one cycle after the grant.
//
// Optional feature (macro CDB_ARB_BR_PRIORITY_EN):
//   Defined   - the branch station has fixed top priority and always takes
//               port 0 when it is valid. Round-robin covers only the ALU
//               stations, so rr_ptr never points at the branch station.
//   Undefined - the branch station is an ordinary round-robin member.
//   Requires NUM_REQ >= 2 when defined.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   flush      branch-mispredict flush; suppresses grants and clears the
//              pending broadcast and the pointer
//   req_valid  per-requester result valid
//   req_tag    per-requester ROB tag, slice [i*TAG_W +: TAG_W]
//   req_data   per-requester result, slice [i*DATA_W +: DATA_W]
//   req_ready  per-requester grant (combinational)
//   bus_valid  per-port broadcast valid (registered)
//   bus_tag    per-port broadcast ROB tag (registered)
//   bus_data   per-port broadcast data (registered)
//   rr_ptr_o   current highest-priority requester index (debug)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32,
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]        bus_valid,
  output logic [NUM_PORTS*TAG_W-1:0]  bus_tag,
  output logic [NUM_PORTS*DATA_W-1:0] bus_data,
  output logic [PTR_W-1:0]            rr_ptr_o
);

`ifdef CDB_ARB_BR_PRIORITY_EN
  // Branch station sits outside the rotation; only ALU stations rotate.
  localparam int RR_N = NUM_REQ - 1;
`else
  localparam int RR_N = NUM_REQ;
`endif

  logic [NUM_PORTS-1:0]        bus_valid_q, bus_valid_d;
  logic [NUM_PORTS*TAG_W-1:0]  bus_tag_q,   bus_tag_d;
  logic [NUM_PORTS*DATA_W-1:0] bus_data_q,  bus_data_d;
  logic [PTR_W-1:0]            rr_ptr_q,    rr_ptr_d;
  logic [NUM_REQ-1:0]          grant;

  // Grant scan: walk requesters from rr_ptr in rotating order and hand the
  // first NUM_PORTS valid ones to ports 0,1,... in scan order.
  always_comb begin
    int cnt;
    int idx;
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves a value unassigned and no latch is inferred.
    grant      = '0;
    bus_valid_d = '0;
    bus_tag_d   = '0;
    bus_data_d  = '0;
    rr_ptr_d    = rr_ptr_q;
    cnt         = 0;
    idx         = 0;

    if (rst || flush) begin
      // No grants during reset/flush; pointer restarts at requester 0.
      rr_ptr_d = '0;
    end else begin
`ifdef CDB_ARB_BR_PRIORITY_EN
      if (req_valid[NUM_REQ-1]) begin
        grant[NUM_REQ-1]          = 1'b1;
        bus_valid_d[0]            = 1'b1;
        bus_tag_d[0 +: TAG_W]     = req_tag[(NUM_REQ-1)*TAG_W +: TAG_W];
        bus_data_d[0 +: DATA_W]   = req_data[(NUM_REQ-1)*DATA_W +: DATA_W];
        cnt                       = 1;
      end
`endif
      for (int k = 0; k < RR_N; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= RR_N) idx = idx - RR_N;
        if (req_valid[idx] && (cnt < NUM_PORTS)) begin
          grant[idx]                      = 1'b1;
          bus_valid_d[cnt]                = 1'b1;
          bus_tag_d[cnt*TAG_W +: TAG_W]   = req_tag[idx*TAG_W +: TAG_W];
          bus_data_d[cnt*DATA_W +: DATA_W] = req_data[idx*DATA_W +: DATA_W];
          cnt                             = cnt + 1;
          // Last rotating winner seen so far sets the next starting point.
          rr_ptr_d                        = PTR_W'((idx + 1) % RR_N);
        end
      end
    end
  end

  // Output registers load every cycle; idle ports carry zero tag/data.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      bus_valid_q <= '0;
      bus_tag_q   <= '0;
      bus_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      bus_valid_q <= bus_valid_d;
      bus_tag_q   <= bus_tag_d;
      bus_data_q  <= bus_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = grant;
  assign bus_valid = bus_valid_q;
  assign bus_tag   = bus_tag_q;
  assign bus_data  = bus_data_q;
  assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed-vector bench for cdb_arbiter in its default configuration
// (NUM_REQ=5, NUM_PORTS=2, TAG_W=3, DATA_W=32, branch priority disabled).
// Inputs change 1 ns after the rising edge; registered outputs are sampled
// then, combinational grants 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NUM_REQ   = 5;
  localparam int NUM_PORTS = 2;
  localparam int TAG_W     = 3;
  localparam int DATA_W    = 32;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*TAG_W-1:0]    req_tag;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_PORTS-1:0]        bus_valid;
  logic [NUM_PORTS*TAG_W-1:0]  bus_tag;
  logic [NUM_PORTS*DATA_W-1:0] bus_data;
  logic [2:0]                  rr_ptr_o;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PORTS(NUM_PORTS),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_data (req_data),
    .req_ready(req_ready),
    .bus_valid(bus_valid),
    .bus_tag  (bus_tag),
    .bus_data (bus_data),
    .rr_ptr_o (rr_ptr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a requester/flush/reset pattern and let combinational grants settle.
  task automatic apply(input logic [4:0] v, input logic f, input logic r);
    req_valid = v;
    flush     = f;
    rst       = r;
    #1;
  endtask

  // Default payloads: requester i carries tag i and data 0x1000+i.
  task automatic default_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = TAG_W'(i);
      req_data[i*DATA_W +: DATA_W] = 32'h1000 + 32'(i);
    end
  endtask

  initial begin
    default_payload();

    // Reset held two cycles with all requesters valid.
    apply(5'b11111, 1'b0, 1'b1);
    check("rst_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    check("rst_bus_valid", 64'(bus_valid), 64'h0);
    check("rst_ptr", 64'(rr_ptr_o), 64'd0);
    check("rst_bus_data", bus_data, 64'h0);

    // Saturation: grant order {0,1},{2,3},{4}; pointer 0->2->4->0.
    apply(5'b11111, 1'b0, 1'b0);
    check("sat1_ready", 64'(req_ready), 64'b00011);
    tick();
    check("sat1_valid", 64'(bus_valid), 64'b11);
    check("sat1_tag", 64'(bus_tag), 64'b001_000);
    check("sat1_data", bus_data, 64'h0000_1001_0000_1000);
    check("sat1_ptr", 64'(rr_ptr_o), 64'd2);
    apply(5'b11100, 1'b0, 1'b0);
    check("sat2_ready", 64'(req_ready), 64'b01100);
    tick();
    check("sat2_tag", 64'(bus_tag), 64'b011_010);
    check("sat2_ptr", 64'(rr_ptr_o), 64'd4);
    apply(5'b10000, 1'b0, 1'b0);
    check("sat3_ready", 64'(req_ready), 64'b10000);
    tick();
    check("sat3_valid", 64'(bus_valid), 64'b01);
    check("sat3_tag", 64'(bus_tag), 64'b000_100);
    check("sat3_ptr", 64'(rr_ptr_o), 64'd0);

    // Idle cycle: no grants, pointer holds.
    apply(5'b00000, 1'b0, 1'b0);
    check("idle_ready", 64'(req_ready), 64'h0);
    tick();
    check("idle_valid", 64'(bus_valid), 64'b00);
    check("idle_ptr", 64'(rr_ptr_o), 64'd0);

    // Single requester 2 with tag 5 and data DEADBEEF.
    req_tag[2*TAG_W +: TAG_W]    = 3'd5;
    req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    apply(5'b00100, 1'b0, 1'b0);
    check("single_ready", 64'(req_ready), 64'b00100);
    tick();
    check("single_valid", 64'(bus_valid), 64'b01);
    check("single_tag", 64'(bus_tag), 64'b000_101);
    check("single_data", bus_data, 64'h0000_0000_DEAD_BEEF);
    check("single_ptr", 64'(rr_ptr_o), 64'd3);
    default_payload();

    // Move pointer to 4 via requester 3, then wrap: valid bits 4 and 1.
    apply(5'b01000, 1'b0, 1'b0);
    check("pre_wrap_ready", 64'(req_ready), 64'b01000);
    tick();
    check("pre_wrap_ptr", 64'(rr_ptr_o), 64'd4);
    apply(5'b10010, 1'b0, 1'b0);
    check("wrap_ready", 64'(req_ready), 64'b10010);
    tick();
    check("wrap_valid", 64'(bus_valid), 64'b11);
    check("wrap_tag", 64'(bus_tag), 64'b001_100);
    check("wrap_data", bus_data, 64'h0000_1001_0000_1004);
    check("wrap_ptr", 64'(rr_ptr_o), 64'd2);

    // Flush: grant 0,1 at t; flush at t+1 with 2,3 valid.
    apply(5'b00011, 1'b0, 1'b0);
    check("fl_t_ready", 64'(req_ready), 64'b00011);
    tick();
    check("fl_t1_valid", 64'(bus_valid), 64'b11);
    check("fl_t1_tag", 64'(bus_tag), 64'b001_000);
    apply(5'b01100, 1'b1, 1'b0);
    check("fl_t1_ready", 64'(req_ready), 64'h0);
    tick();
    check("fl_t2_valid", 64'(bus_valid), 64'b00);
    check("fl_t2_tag", 64'(bus_tag), 64'h0);
    check("fl_t2_ptr", 64'(rr_ptr_o), 64'd0);

    // Rotation from pointer 1 with all valid: port0=req1, port1=req2.
    apply(5'b00001, 1'b0, 1'b0);
    check("rot_pre_ready", 64'(req_ready), 64'b00001);
    tick();
    check("rot_pre_ptr", 64'(rr_ptr_o), 64'd1);
    apply(5'b11111, 1'b0, 1'b0);
    check("rot_ready", 64'(req_ready), 64'b00110);
    tick();
    check("rot_tag", 64'(bus_tag), 64'b010_001);
    check("rot_ptr", 64'(rr_ptr_o), 64'd3);

    // Simultaneous flush and reset: identical to plain reset.
    apply(5'b11111, 1'b1, 1'b1);
    check("flrst_ready", 64'(req_ready), 64'h0);
    tick();
    check("flrst_valid", 64'(bus_valid), 64'b00);
    check("flrst_ptr", 64'(rr_ptr_o), 64'd0);
    check("flrst_data", bus_data, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
